// File: rtl/usb_fifo_pkg.sv
// Shared constants and helpers for the USB host controller FIFOs.
// The defaults match the dual-clock FIFO so that both buffer types are interchangeable.
package usb_fifo_pkg;

  localparam int USB_FIFO_DATASIZE = 8;
  localparam int USB_FIFO_ADDRSIZE = 5;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_fifo_ram.sv
// FIFO storage array with one synchronous write port and one asynchronous read port.
// It has no reset so that synthesis can map it onto distributed or block RAM.
module usb_fifo_ram
  import usb_fifo_pkg::*;
#(
  parameter int DATASIZE = USB_FIFO_DATASIZE,
  parameter int ADDRSIZE = USB_FIFO_ADDRSIZE
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDRSIZE-1:0] i_waddr,
  input  logic [DATASIZE-1:0] i_wdata,
  input  logic [ADDRSIZE-1:0] i_raddr,
  output logic [DATASIZE-1:0] o_rdata
);

  logic [DATASIZE-1:0] r_mem [0:(1<<ADDRSIZE)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/usb_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// FWFT or registered read, synchronous flush and sticky error flags.
module usb_sync_fifo
  import usb_fifo_pkg::*;
#(
  parameter int DATASIZE      = USB_FIFO_DATASIZE,
  parameter int ADDRSIZE      = USB_FIFO_ADDRSIZE,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                write_enable,
  input  logic [DATASIZE-1:0] write_data,
  input  logic                read_enable,
  output logic [DATASIZE-1:0] read_data,
  output logic                read_valid,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LP_FULL_CNT = CNT_W'(DEPTH);

  logic [ADDRSIZE-1:0] r_wptr;
  logic [ADDRSIZE-1:0] r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_ovf;
  logic                r_unf;
  logic                r_read_valid;
  logic [DATASIZE-1:0] r_read_data;
  logic [DATASIZE-1:0] w_ram_rdata;
  logic                w_rd_acc;
  logic                w_wr_acc;
  logic                w_ram_we;

  // A write into a full FIFO is only safe when the head is popped on the same edge.
  assign w_rd_acc = read_enable & ~r_empty;
  assign w_wr_acc = write_enable & (~r_full | w_rd_acc);
  assign w_ram_we = w_wr_acc & ~rst & ~flush;

  usb_fifo_ram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_wptr),
    .i_wdata (write_data),
    .i_raddr (r_rptr),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc)      w_count_nxt = r_count + 1'b1;
    else if (w_rd_acc && !w_wr_acc) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_aempty     <= 1'b1;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_read_valid <= 1'b0;
      r_read_data  <= '0;
    end else if (flush) begin
      // Requests coinciding with a flush are dropped silently; read_data keeps its value.
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_afull      <= 1'b0;
      r_aempty     <= 1'b1;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_read_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count      <= w_count_nxt;
      r_full       <= (w_count_nxt == LP_FULL_CNT);
      r_empty      <= (w_count_nxt == '0);
      r_afull      <= (int'(w_count_nxt) >= AFULL_THRESH);
      r_aempty     <= (int'(w_count_nxt) <= AEMPTY_THRESH);
      if (write_enable && !w_wr_acc) r_ovf <= 1'b1;
      if (read_enable && !w_rd_acc)  r_unf <= 1'b1;
      r_read_valid <= w_rd_acc;
      if (w_rd_acc) r_read_data <= w_ram_rdata;
    end
  end

  assign read_data    = FWFT ? w_ram_rdata : r_read_data;
  assign read_valid   = FWFT ? ~r_empty : r_read_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;

endmodule

// File: tb/tb_usb_sync_fifo.sv
// Self-checking bench: a registered-read instance checked against a queue model and
// scoreboard, plus an FWFT instance exercised with fixed expected values.
module tb_usb_sync_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst = 1'b1, a_flush = 1'b0, a_we = 1'b0, a_re = 1'b0;
  logic [7:0] a_wd = '0, a_rd;
  logic       a_rv, a_full, a_empty, a_afull, a_aempty, a_ovf, a_unf;
  logic [5:0] a_cnt;

  logic       b_rst = 1'b1, b_flush = 1'b0, b_we = 1'b0, b_re = 1'b0;
  logic [7:0] b_wd = '0, b_rd;
  logic       b_rv, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [5:0] b_cnt;

  usb_sync_fifo #(.FWFT(1'b0)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush), .write_enable(a_we), .write_data(a_wd),
    .read_enable(a_re), .read_data(a_rd), .read_valid(a_rv), .full(a_full), .empty(a_empty),
    .almost_full(a_afull), .almost_empty(a_aempty), .count(a_cnt), .overflow(a_ovf),
    .underflow(a_unf)
  );

  usb_sync_fifo #(.FWFT(1'b1)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush), .write_enable(b_we), .write_data(b_wd),
    .read_enable(b_re), .read_data(b_rd), .read_valid(b_rv), .full(b_full), .empty(b_empty),
    .almost_full(b_afull), .almost_empty(b_aempty), .count(b_cnt), .overflow(b_ovf),
    .underflow(b_unf)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic [7:0] sb[$];
  bit         m_ovf, m_unf, m_valid;

  task automatic a_reset();
    a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_flush = 1'b0;
    @(posedge clk); #1;
    a_rst = 1'b0;
    mq.delete(); sb.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
  endtask

  // Drive one cycle on instance A and advance the behavioural queue model.
  task automatic a_op(input bit we, input logic [7:0] wd, input bit re);
    bit rd_acc, wr_acc;
    rd_acc = re && (mq.size() != 0);
    wr_acc = we && (mq.size() != 32 || rd_acc);
    if (we && !wr_acc) m_ovf = 1'b1;
    if (re && !rd_acc) m_unf = 1'b1;
    m_valid = rd_acc;
    if (rd_acc) sb.push_back(mq.pop_front());
    if (wr_acc) mq.push_back(wd);
    a_we = we; a_wd = wd; a_re = re;
    @(posedge clk); #1;
    a_we = 1'b0; a_re = 1'b0;
  endtask

  task automatic b_op(input bit fl, input bit we, input logic [7:0] wd, input bit re);
    b_flush = fl; b_we = we; b_wd = wd; b_re = re;
    @(posedge clk); #1;
    b_flush = 1'b0; b_we = 1'b0; b_re = 1'b0;
  endtask

  task automatic test_reset();
    a_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got %b exp 1", a_empty); end
    checks++; if (a_aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b exp 1", a_aempty); end
    checks++; if (a_cnt !== 6'd0)    begin errors++; $display("FAIL reset_count got %0d exp 0", a_cnt); end
    checks++; if (a_full !== 1'b0 || a_afull !== 1'b0) begin errors++; $display("FAIL reset_full got %b/%b exp 0/0", a_full, a_afull); end
    checks++; if (a_ovf !== 1'b0 || a_unf !== 1'b0) begin errors++; $display("FAIL reset_err got %b/%b exp 0/0", a_ovf, a_unf); end
    checks++; if (a_rv !== 1'b0 || a_rd !== 8'h00) begin errors++; $display("FAIL reset_read got rv=%b rd=%h exp 0/00", a_rv, a_rd); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 32; i++) begin
      a_op(1'b1, 8'(i), 1'b0);
      checks++; if (a_cnt !== 6'(i + 1)) begin errors++; $display("FAIL fill_count i=%0d got %0d exp %0d", i, a_cnt, i + 1); end
      checks++; if (a_afull !== (i + 1 >= 28)) begin errors++; $display("FAIL fill_afull i=%0d got %b", i, a_afull); end
      checks++; if (a_aempty !== (i + 1 <= 4)) begin errors++; $display("FAIL fill_aempty i=%0d got %b", i, a_aempty); end
      checks++; if (a_full !== (i == 31) || a_empty !== 1'b0) begin errors++; $display("FAIL fill_full i=%0d got full=%b empty=%b", i, a_full, a_empty); end
    end
    a_op(1'b1, 8'hEE, 1'b0);
    checks++; if (a_ovf !== 1'b1) begin errors++; $display("FAIL overflow got %b exp 1", a_ovf); end
    checks++; if (a_cnt !== 6'd32 || a_full !== 1'b1) begin errors++; $display("FAIL overflow_count got %0d full=%b exp 32/1", a_cnt, a_full); end
  endtask

  task automatic test_drain();
    logic [7:0] exp;
    for (int i = 0; i < 32; i++) begin
      a_op(1'b0, 8'h00, 1'b1);
      checks++;
      if (a_rv !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL drain_valid i=%0d got %b exp 1", i, a_rv);
      end else begin
        exp = sb.pop_front();
        if (a_rd !== exp || a_rd !== 8'(i)) begin errors++; $display("FAIL drain_data i=%0d got %h exp %h", i, a_rd, exp); end
      end
      checks++; if (a_empty !== (i == 31)) begin errors++; $display("FAIL drain_empty i=%0d got %b", i, a_empty); end
    end
    a_op(1'b0, 8'h00, 1'b1);
    checks++; if (a_unf !== 1'b1) begin errors++; $display("FAIL underflow got %b exp 1", a_unf); end
    checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL underflow_valid got %b exp 0", a_rv); end
    checks++; if (a_ovf !== m_ovf) begin errors++; $display("FAIL overflow_sticky got %b exp %b", a_ovf, m_ovf); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    a_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 20; k++) a_op(1'b1, 8'(8'h80 + r * 20 + k), 1'b0);
      checks++; if (a_cnt !== 6'd20) begin errors++; $display("FAIL wrap_count_full r=%0d got %0d exp 20", r, a_cnt); end
      for (int k = 0; k < 20; k++) begin
        a_op(1'b0, 8'h00, 1'b1);
        checks++;
        if (a_rv !== m_valid || sb.size() == 0) begin
          errors++; $display("FAIL wrap_valid r=%0d k=%0d got %b", r, k, a_rv);
        end else begin
          exp = sb.pop_front();
          if (a_rd !== exp) begin errors++; $display("FAIL wrap_data r=%0d k=%0d got %h exp %h", r, k, a_rd, exp); end
        end
      end
      checks++; if (a_cnt !== 6'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL wrap_count_end r=%0d got %0d", r, a_cnt); end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    a_reset();
    for (int i = 0; i < 32; i++) a_op(1'b1, 8'(8'h40 + i), 1'b0);
    a_op(1'b1, 8'hAA, 1'b1);
    checks++; if (a_cnt !== 6'd32 || a_full !== 1'b1) begin errors++; $display("FAIL simul_full_count got %0d exp 32", a_cnt); end
    checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL simul_full_ovf got %b exp 0", a_ovf); end
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    checks++; if (a_rv !== 1'b1 || a_rd !== exp) begin errors++; $display("FAIL simul_full_data got %h exp %h", a_rd, exp); end
    for (int i = 0; i < 32; i++) begin
      a_op(1'b0, 8'h00, 1'b1);
      exp = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
      checks++; if (a_rv !== 1'b1 || a_rd !== exp) begin errors++; $display("FAIL simul_drain i=%0d got %h exp %h", i, a_rd, exp); end
    end
    checks++; if (a_rd !== 8'hAA) begin errors++; $display("FAIL simul_last got %h exp aa", a_rd); end
    a_op(1'b1, 8'h55, 1'b1);
    checks++; if (a_cnt !== 6'd1 || a_unf !== m_unf || a_unf !== 1'b1) begin errors++; $display("FAIL simul_empty got cnt=%0d unf=%b exp 1/1", a_cnt, a_unf); end
    checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL simul_empty_valid got %b exp 0", a_rv); end
    a_op(1'b0, 8'h00, 1'b1);
    exp = (sb.size() != 0) ? sb.pop_front() : 8'hXX;
    checks++; if (a_rv !== 1'b1 || a_rd !== exp || a_rd !== 8'h55) begin errors++; $display("FAIL simul_55 got %h exp 55", a_rd); end
  endtask

  task automatic test_fwft_flush();
    b_rst = 1'b1;
    @(posedge clk); #1;
    b_rst = 1'b0;
    b_op(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (b_unf !== 1'b1 || b_rv !== 1'b0) begin errors++; $display("FAIL fwft_unf got unf=%b rv=%b exp 1/0", b_unf, b_rv); end
    b_op(1'b0, 1'b1, 8'h3C, 1'b0);
    checks++; if (b_rd !== 8'h3C || b_rv !== 1'b1) begin errors++; $display("FAIL fwft_first got %h rv=%b exp 3c/1", b_rd, b_rv); end
    for (int i = 1; i < 5; i++) b_op(1'b0, 1'b1, 8'(8'h3C + i), 1'b0);
    checks++; if (b_cnt !== 6'd5 || b_rd !== 8'h3C) begin errors++; $display("FAIL fwft_hold got cnt=%0d rd=%h exp 5/3c", b_cnt, b_rd); end
    b_op(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (b_rd !== 8'h3D || b_cnt !== 6'd4 || b_rv !== 1'b1) begin errors++; $display("FAIL fwft_pop got %h cnt=%0d exp 3d/4", b_rd, b_cnt); end
    b_op(1'b0, 1'b1, 8'h41, 1'b0);
    checks++; if (b_cnt !== 6'd5) begin errors++; $display("FAIL fwft_refill got %0d exp 5", b_cnt); end
    b_op(1'b1, 1'b1, 8'h99, 1'b1);
    checks++; if (b_cnt !== 6'd0 || b_empty !== 1'b1 || b_rv !== 1'b0) begin errors++; $display("FAIL flush_count got cnt=%0d empty=%b rv=%b exp 0/1/0", b_cnt, b_empty, b_rv); end
    checks++; if (b_unf !== 1'b0 || b_ovf !== 1'b0) begin errors++; $display("FAIL flush_err got unf=%b ovf=%b exp 0/0", b_unf, b_ovf); end
    checks++; if (b_aempty !== 1'b1 || b_afull !== 1'b0 || b_full !== 1'b0) begin errors++; $display("FAIL flush_flags got ae=%b af=%b f=%b", b_aempty, b_afull, b_full); end
    b_op(1'b0, 1'b1, 8'h77, 1'b0);
    checks++; if (b_rd !== 8'h77 || b_cnt !== 6'd1) begin errors++; $display("FAIL flush_after got %h cnt=%0d exp 77/1", b_rd, b_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_fwft_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
